// File: rtl/uart_eep_cmd_parser.sv
// Command-framing stage between the UART and the I2C EEPROM byte controller.
// It collects HDR/CMD/ADDR_H/ADDR_L/LEN (and the write payload) from the UART,
// then issues one EEPROM byte request at a time with an auto-incrementing address.
// Read bytes, or a single ack byte after a write, are sent back to the UART.
module uart_eep_cmd_parser #(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter logic [7:0]  HDR_BYTE    = 8'h55,
    parameter logic [7:0]  WR_ACK_BYTE = 8'hAA
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  Rx_data,
    input  logic        Rx_done,
    output logic [7:0]  Tx_data,
    output logic        Tx_start,
    input  logic        Tx_done,
    output logic        Eep_wr_req,
    output logic        Eep_rd_req,
    output logic [15:0] Eep_addr,
    output logic [7:0]  Eep_wr_data,
    input  logic [7:0]  Eep_rd_data,
    input  logic        Eep_ack,
    output logic        Busy,
    output logic        Err
);

    localparam int unsigned BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_AH,
        S_GET_AL,
        S_GET_LEN,
        S_GET_DATA,
        S_WR_REQ,
        S_WR_ACKTX,
        S_RD_REQ,
        S_RD_TX,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            is_rd_q, is_rd_d;
    logic [15:0]     addr_q, addr_d;
    logic [8:0]      len_q, len_d;
    logic [8:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            gap_q, gap_d;
    logic            sent_q, sent_d;
    logic [7:0]      rd_byte_q, rd_byte_d;
    logic [7:0]      buf_q [MAX_LEN];
    logic            buf_we;
    logic [8:0]      idx_inc;
    logic            idx_last;
    logic            in_rx;
    logic            in_exec;

    assign idx_inc  = idx_q + 9'd1;
    assign idx_last = (idx_inc == len_q);
    assign in_rx    = state_q inside {S_GET_CMD, S_GET_AH, S_GET_AL, S_GET_LEN, S_GET_DATA};
    assign in_exec  = state_q inside {S_WR_REQ, S_WR_ACKTX, S_RD_REQ, S_RD_TX, S_DONE};

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            is_rd_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            gap_q     <= 1'b0;
            sent_q    <= 1'b0;
            rd_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            is_rd_q   <= is_rd_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            gap_q     <= gap_d;
            sent_q    <= sent_d;
            rd_byte_q <= rd_byte_d;
        end
    end

    // Payload buffer; contents need no reset since the index gates every read
    always_ff @(posedge Clk) begin
        if (buf_we) begin
            buf_q[idx_q[BW-1:0]] <= Rx_data;
        end
    end

    // Next-state logic: frame reception, timeout and one-at-a-time execution
    always_comb begin
        state_d   = state_q;
        is_rd_d   = is_rd_q;
        addr_d    = addr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_d     = '0;
        err_d     = 1'b0;
        gap_d     = gap_q;
        sent_d    = sent_q;
        rd_byte_d = rd_byte_q;
        buf_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Rx_done && (Rx_data == HDR_BYTE)) begin
                    state_d = S_GET_CMD;
                end
            end
            S_GET_CMD: begin
                if (Rx_done) begin
                    if ((Rx_data == 8'h01) || (Rx_data == 8'h02)) begin
                        is_rd_d = (Rx_data == 8'h02);
                        state_d = S_GET_AH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_GET_AH: begin
                if (Rx_done) begin
                    addr_d[15:8] = Rx_data;
                    state_d      = S_GET_AL;
                end
            end
            S_GET_AL: begin
                if (Rx_done) begin
                    addr_d[7:0] = Rx_data;
                    state_d     = S_GET_LEN;
                end
            end
            S_GET_LEN: begin
                if (Rx_done) begin
                    if ((Rx_data == 8'h00) || ({1'b0, Rx_data} > 9'(MAX_LEN))) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        len_d   = {1'b0, Rx_data};
                        idx_d   = '0;
                        sent_d  = 1'b0;
                        state_d = is_rd_q ? S_RD_REQ : S_GET_DATA;
                    end
                end
            end
            S_GET_DATA: begin
                if (Rx_done) begin
                    buf_we = 1'b1;
                    if (idx_last) begin
                        idx_d   = '0;
                        gap_d   = 1'b0;
                        state_d = S_WR_REQ;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_WR_REQ: begin
                // gap_q forces one idle request cycle between consecutive writes
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (Eep_ack) begin
                    addr_d = addr_q + 16'd1;
                    if (idx_last) begin
                        sent_d  = 1'b0;
                        state_d = S_WR_ACKTX;
                    end else begin
                        idx_d = idx_inc;
                        gap_d = 1'b1;
                    end
                end
            end
            S_WR_ACKTX: begin
                if (!sent_q) begin
                    sent_d = 1'b1;
                end else if (Tx_done) begin
                    state_d = S_DONE;
                end
            end
            S_RD_REQ: begin
                if (Eep_ack) begin
                    rd_byte_d = Eep_rd_data;
                    sent_d    = 1'b0;
                    state_d   = S_RD_TX;
                end
            end
            S_RD_TX: begin
                if (!sent_q) begin
                    sent_d = 1'b1;
                end else if (Tx_done) begin
                    addr_d = addr_q + 16'd1;
                    if (idx_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A received byte always restarts the inter-byte timer, even on expiry
        if (in_rx && !Rx_done) begin
            if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (in_exec && Rx_done) begin
            err_d = 1'b1;
        end
    end

    // Output decode from registered state
    always_comb begin
        Eep_wr_req  = (state_q == S_WR_REQ) && !gap_q;
        Eep_rd_req  = (state_q == S_RD_REQ);
        Eep_addr    = addr_q;
        Eep_wr_data = '0;
        Tx_start    = 1'b0;
        Tx_data     = '0;
        Busy        = in_exec;
        Err         = err_q;
        if (Eep_wr_req) begin
            Eep_wr_data = buf_q[idx_q[BW-1:0]];
        end
        if (state_q == S_WR_ACKTX) begin
            Tx_start = !sent_q;
            Tx_data  = WR_ACK_BYTE;
        end else if (state_q == S_RD_TX) begin
            Tx_start = !sent_q;
            Tx_data  = rd_byte_q;
        end
    end

endmodule

// File: tb/tb_uart_eep_cmd_parser.sv
// Directed bench for uart_eep_cmd_parser: a frame-level model builds the expected
// EEPROM requests and UART bytes, and one monitor process checks them every cycle
// while also acting as the EEPROM controller and UART transmitter.
module tb_uart_eep_cmd_parser;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned TMO     = 100;

    typedef logic [7:0] bq_t [$];

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [7:0]  Rx_data;
    logic        Rx_done;
    logic [7:0]  Tx_data;
    logic        Tx_start;
    logic        Tx_done = 1'b0;
    logic        Eep_wr_req;
    logic        Eep_rd_req;
    logic [15:0] Eep_addr;
    logic [7:0]  Eep_wr_data;
    logic [7:0]  Eep_rd_data = 8'h00;
    logic        Eep_ack = 1'b0;
    logic        Busy;
    logic        Err;

    always #5 Clk = ~Clk;

    uart_eep_cmd_parser #(
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT_CYC(TMO),
        .HDR_BYTE   (8'h55),
        .WR_ACK_BYTE(8'hAA)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Rx_data    (Rx_data),
        .Rx_done    (Rx_done),
        .Tx_data    (Tx_data),
        .Tx_start   (Tx_start),
        .Tx_done    (Tx_done),
        .Eep_wr_req (Eep_wr_req),
        .Eep_rd_req (Eep_rd_req),
        .Eep_addr   (Eep_addr),
        .Eep_wr_data(Eep_wr_data),
        .Eep_rd_data(Eep_rd_data),
        .Eep_ack    (Eep_ack),
        .Busy       (Busy),
        .Err        (Err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int err_seen    = 0;
    int err_exp     = 0;

    logic [23:0] wr_exp [$];
    logic [23:0] wr_log [$];
    logic [15:0] rd_exp [$];
    logic [15:0] rd_log [$];
    logic [7:0]  tx_exp [$];
    logic [7:0]  tx_log [$];

    bit ack_en    = 1'b1;
    bit force_ack = 1'b0;
    int ack_delay = 2;
    int ack_wait  = 0;
    bit tx_await  = 1'b0;
    int tx_cnt    = 0;
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // EEPROM contents served by the bench's controller model
    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'hFFFE: return 8'h5A;
            16'hFFFF: return 8'h6B;
            16'h0000: return 8'h7C;
            default:  return a[7:0] ^ a[15:8] ^ 8'hC3;
        endcase
    endfunction

    // Frame-level model: what a complete frame must produce
    task automatic model_frame(input bq_t fr);
        logic [15:0] a;
        int          n;
        if (fr.size() < 2 || fr[0] != 8'h55) return;
        if (fr[1] != 8'h01 && fr[1] != 8'h02) begin
            err_exp++;
            return;
        end
        if (fr.size() < 5) return;
        a = {fr[2], fr[3]};
        n = int'(fr[4]);
        if (n == 0 || n > int'(MAX_LEN)) begin
            err_exp++;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (fr[1] == 8'h01) begin
                wr_exp.push_back({a, fr[5 + i]});
            end else begin
                rd_exp.push_back(a);
                tx_exp.push_back(rom(a));
            end
            a = a + 16'd1;
        end
        if (fr[1] == 8'h01) tx_exp.push_back(8'hAA);
    endtask

    // Compare process plus EEPROM controller and UART transmitter models
    always @(negedge Clk) begin
        logic [23:0] we;
        logic [15:0] re;
        logic [7:0]  te;
        if (Eep_wr_req || Eep_rd_req)
            chk("req_exclusive", 32'(Eep_wr_req & Eep_rd_req), 32'd0);
        if (Err) err_seen++;
        if (Eep_wr_req && !prev_wr) begin
            wr_log.push_back({Eep_addr, Eep_wr_data});
            chk("wr_expected", 32'(wr_exp.size() != 0), 32'd1);
            if (wr_exp.size() != 0) begin
                we = wr_exp.pop_front();
                chk("wr_addr_data", 32'({Eep_addr, Eep_wr_data}), 32'(we));
            end
        end
        if (Eep_rd_req && !prev_rd) begin
            rd_log.push_back(Eep_addr);
            chk("rd_expected", 32'(rd_exp.size() != 0), 32'd1);
            if (rd_exp.size() != 0) begin
                re = rd_exp.pop_front();
                chk("rd_addr", 32'(Eep_addr), 32'(re));
            end
        end
        if (Tx_start) begin
            chk("tx_not_overlapped", 32'(tx_await), 32'd0);
            tx_log.push_back(Tx_data);
            chk("tx_expected", 32'(tx_exp.size() != 0), 32'd1);
            if (tx_exp.size() != 0) begin
                te = tx_exp.pop_front();
                chk("tx_byte", 32'(Tx_data), 32'(te));
            end
            tx_await = 1'b1;
            tx_cnt   = 0;
        end
        prev_wr = Eep_wr_req;
        prev_rd = Eep_rd_req;

        Tx_done = 1'b0;
        if (tx_await) begin
            tx_cnt++;
            if (tx_cnt == 3) begin
                Tx_done  = 1'b1;
                tx_await = 1'b0;
            end
        end

        Eep_ack = 1'b0;
        if (force_ack) begin
            Eep_ack   = 1'b1;
            force_ack = 1'b0;
        end else if (ack_en && (Eep_wr_req || Eep_rd_req)) begin
            if (ack_wait >= ack_delay) begin
                Eep_ack = 1'b1;
                if (Eep_rd_req) Eep_rd_data = rom(Eep_addr);
                ack_wait = 0;
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        Rx_data = b;
        Rx_done = 1'b1;
        @(negedge Clk);
        Rx_done = 1'b0;
    endtask

    task automatic run_frame(input bq_t fr);
        model_frame(fr);
        foreach (fr[i]) begin
            if (i != 0) @(negedge Clk);
            send_byte(fr[i]);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((Busy || wr_exp.size() != 0 || rd_exp.size() != 0 || tx_exp.size() != 0 || tx_await)
               && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        chk({name, "_completes"}, 32'(n < 2000), 32'd1);
        repeat (2) @(negedge Clk);
        chk({name, "_busy_low"}, 32'(Busy), 32'd0);
        chk({name, "_err_count"}, 32'(err_seen), 32'(err_exp));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_wr_req"}, 32'(Eep_wr_req), 32'd0);
        chk({name, "_rd_req"}, 32'(Eep_rd_req), 32'd0);
        chk({name, "_addr"},   32'(Eep_addr),   32'd0);
        chk({name, "_wdata"},  32'(Eep_wr_data), 32'd0);
        chk({name, "_tx"},     32'({Tx_start, Tx_data}), 32'd0);
        chk({name, "_busy"},   32'(Busy), 32'd0);
        chk({name, "_err"},    32'(Err),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bq_t fr;
        Rst_n   = 1'b0;
        Rx_done = 1'b0;
        Rx_data = 8'h00;
        repeat (3) @(negedge Clk);
        chk_all_zero("reset");
        Rst_n = 1'b1;
        @(negedge Clk);

        // Write frame of three bytes
        wr_log.delete(); tx_log.delete();
        fr = {8'h55, 8'h01, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
        run_frame(fr);
        chk("wr_req_latency", 32'(Eep_wr_req), 32'd1);
        chk("wr_busy_rise", 32'(Busy), 32'd1);
        wait_idle("write3");
        chk("write3_n", 32'(wr_log.size()), 32'd3);
        if (wr_log.size() == 3) begin
            chk("write3_0", 32'(wr_log[0]), 32'h001011);
            chk("write3_1", 32'(wr_log[1]), 32'h001122);
            chk("write3_2", 32'(wr_log[2]), 32'h001233);
        end
        chk("write3_ackbyte", 32'(tx_log.size() == 1 ? tx_log[0] : 8'h00), 32'h0AA);

        // Read frame wrapping through 16'hFFFF
        rd_log.delete(); tx_log.delete();
        fr = {8'h55, 8'h02, 8'hFF, 8'hFE, 8'h03};
        run_frame(fr);
        chk("rd_req_latency", 32'(Eep_rd_req), 32'd1);
        chk("rd_busy_rise", 32'(Busy), 32'd1);
        wait_idle("read3");
        chk("read3_n", 32'(rd_log.size() + tx_log.size()), 32'd6);
        if (rd_log.size() == 3 && tx_log.size() == 3) begin
            chk("read3_addr", 32'({rd_log[0], rd_log[1]}), 32'hFFFEFFFF);
            chk("read3_addr2", 32'(rd_log[2]), 32'h0000);
            chk("read3_tx", 32'({tx_log[0], tx_log[1], tx_log[2]}), 32'h5A6B7C);
        end

        // Error frames and a stray byte
        fr = {8'h55, 8'h07};
        run_frame(fr);
        repeat (2) @(negedge Clk);
        chk("badcmd_err", 32'(err_seen), 32'(err_exp));
        chk("badcmd_err_lit", 32'(err_exp), 32'd1);
        fr = {8'h55, 8'h01, 8'h00, 8'h00, 8'h00};
        run_frame(fr);
        repeat (2) @(negedge Clk);
        chk("len0_err", 32'(err_seen), 32'd2);
        fr = {8'h55, 8'h01, 8'h00, 8'h00, 8'h11};
        run_frame(fr);
        repeat (2) @(negedge Clk);
        chk("len17_err", 32'(err_seen), 32'd3);
        chk("len17_busy", 32'(Busy), 32'd0);
        fr = {8'h3C};
        run_frame(fr);
        repeat (3) @(negedge Clk);
        chk("stray_no_err", 32'(err_seen), 32'd3);

        // Maximum length write crossing the address wrap
        wr_log.delete();
        fr = {8'h55, 8'h01, 8'hFF, 8'hF8, 8'h10};
        for (int i = 0; i < 16; i++) fr.push_back(8'(i * 7 + 1));
        run_frame(fr);
        wait_idle("write16");
        chk("write16_n", 32'(wr_log.size()), 32'd16);
        if (wr_log.size() == 16) begin
            chk("write16_8",  32'(wr_log[8]),  32'h000039);
            chk("write16_15", 32'(wr_log[15]), 32'h00076A);
        end

        // Inter-byte timeout, then a normal frame
        fr = {8'h55, 8'h01, 8'h00};
        run_frame(fr);
        err_exp++;
        repeat (99) @(negedge Clk);
        chk("timeout_not_early", 32'(Err), 32'd0);
        @(negedge Clk);
        chk("timeout_err", 32'(Err), 32'd1);
        repeat (2) @(negedge Clk);
        wr_log.delete();
        fr = {8'h55, 8'h01, 8'h00, 8'h20, 8'h02, 8'hA1, 8'hB2};
        run_frame(fr);
        wait_idle("after_timeout");
        chk("after_timeout_1", 32'(wr_log.size() == 2 ? wr_log[1] : 24'h0), 32'h0021B2);

        // Byte injected while a write request is outstanding
        ack_delay = 6;
        wr_log.delete();
        fr = {8'h55, 8'h01, 8'h01, 8'h00, 8'h02, 8'hC3, 8'hD4};
        run_frame(fr);
        chk("inject_req_up", 32'(Eep_wr_req), 32'd1);
        @(negedge Clk);
        send_byte(8'h99);
        err_exp++;
        @(negedge Clk);
        chk("inject_err", 32'(err_seen), 32'(err_exp));
        wait_idle("inject");
        ack_delay = 2;
        chk("inject_data", 32'(wr_log.size() == 2 ? {wr_log[0][7:0], wr_log[1]} : 32'h0), 32'hC30101D4);

        // Reset while a write request is high, then a late ack
        ack_en = 1'b0;
        fr = {8'h55, 8'h01, 8'h12, 8'h34, 8'h01, 8'h77};
        run_frame(fr);
        chk("rst_req_up", 32'(Eep_wr_req), 32'd1);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        chk_all_zero("midrst");
        chk("midrst_wr_seen", 32'(wr_exp.size()), 32'd0);
        tx_exp.delete();
        force_ack = 1'b1;
        repeat (6) @(negedge Clk);
        chk("late_ack_busy", 32'(Busy), 32'd0);
        chk("late_ack_req", 32'({Eep_wr_req, Eep_rd_req}), 32'd0);
        chk("late_ack_err", 32'(err_seen), 32'(err_exp));
        ack_en = 1'b1;
        tx_log.delete();
        fr = {8'h55, 8'h02, 8'h00, 8'h05, 8'h01};
        run_frame(fr);
        wait_idle("after_reset");
        chk("after_reset_tx", 32'(tx_log.size() == 1 ? tx_log[0] : 8'h00), 32'h0C6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_eep_cmd_parser.md
Name: uart_eep_cmd_parser

Overview:
Command-framing stage between the UART receiver/transmitter and the I2C EEPROM byte controller inside the UART-to-EEPROM subsystem. It assembles received UART bytes into command frames and buffers write payloads. It then issues one EEPROM byte request at a time with auto-incrementing address. Read data, and a completion byte for writes, are returned to the UART transmitter.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame; power of two, at most 256.
TIMEOUT_CYC, 50_000_000, inter-byte timeout in Clk cycles while a frame is partially received.
HDR_BYTE, 8'h55, frame header byte.
WR_ACK_BYTE, 8'hAA, byte sent to UART after a write frame completes.

Ports:
Clk  in  1  system clock; all logic on rising edge.
Rst_n  in  1  synchronous active-low reset.
Rx_data  in  8  byte from UART receiver.
Rx_done  in  1  one-cycle pulse; Rx_data valid.
Tx_data  out  8  byte to UART transmitter.
Tx_start  out  1  one-cycle pulse requesting transmission of Tx_data.
Tx_done  in  1  one-cycle pulse; transmitter finished the current byte.
Eep_wr_req  out  1  write request level to EEPROM controller.
Eep_rd_req  out  1  read request level to EEPROM controller.
Eep_addr  out  16  EEPROM byte address.
Eep_wr_data  out  8  write data byte.
Eep_rd_data  in  8  read data; valid when Eep_ack=1 on a read.
Eep_ack  in  1  one-cycle pulse; current request completed.
Busy  out  1  high from frame acceptance until execution completes.
Err  out  1  one-cycle pulse on any frame error.

Behaviour:
- Reset (Rst_n=0 at a rising edge): all outputs 0. State IDLE, payload buffer index 0, timeout counter 0. Applies mid-frame and mid-request; an in-flight Eep_ack or Tx_done after reset is ignored.
- Frame format: HDR, CMD, ADDR_H, ADDR_L, LEN, then LEN payload bytes for writes only.
  - CMD 8'h01 = write; CMD 8'h02 = read.
- States: IDLE, GET_CMD, GET_AH, GET_AL, GET_LEN, GET_DATA, WR_REQ, WR_ACKTX, RD_REQ, RD_TX, DONE.
- IDLE: advances to GET_CMD on Rx_done with Rx_data==HDR_BYTE. Other bytes are silently dropped with no Err.
- GET_CMD: a CMD other than 01/02 pulses Err and returns to IDLE.
- GET_AH / GET_AL: capture the address. Big-endian: first byte is bits 15:8.
- GET_LEN: LEN==0 or LEN>MAX_LEN pulses Err and returns to IDLE. A write goes to GET_DATA; a read goes to RD_REQ.
- GET_DATA: each Rx_done stores the byte at buffer[index] and increments index. After LEN bytes, the next state is WR_REQ.
- Timeout: a counter is active in GET_CMD through GET_DATA and clears on every Rx_done.
  - When it reaches TIMEOUT_CYC-1 with no Rx_done, Err pulses and the state returns to IDLE.
  - If Rx_done and expiry occur in the same cycle, the byte wins.
- Busy rises in the cycle the state leaves GET_LEN (read) or GET_DATA (write), and falls on entry to IDLE after DONE.
- WR_REQ:
  - Eep_wr_req held at 1 with Eep_addr=current address and Eep_wr_data=buffer[k] until Eep_ack.
  - Eep_wr_req drops the cycle after Eep_ack; the address then increments and k increments.
  - After LEN acks, the state moves to WR_ACKTX.
- WR_ACKTX: Tx_start pulses once with Tx_data=WR_ACK_BYTE, then waits for Tx_done before moving to DONE.
- RD_REQ:
  - Eep_rd_req held at 1 until Eep_ack. Eep_rd_data is latched on the Eep_ack cycle.
  - Next state RD_TX: Tx_start pulses with the latched byte, then waits for Tx_done.
  - The address then increments; the FSM repeats RD_REQ until LEN bytes are sent, then goes to DONE.
- Requests: at most one outstanding. Eep_wr_req and Eep_rd_req are never high together. Tx_start is never pulsed while a Tx_done is awaited.
- Address arithmetic: 16-bit, wraps 16'hFFFF to 16'h0000 with no error.
- Rx_done during execution states (WR_REQ through DONE): the byte is discarded and Err pulses. Execution continues unaffected.
- Latency: Eep_wr_req rises one cycle after the Rx_done of the final payload byte. Eep_rd_req rises one cycle after the Rx_done of LEN.
- DONE: lasts one cycle, then IDLE.
- Spurious Eep_ack or Tx_done outside a waiting state is ignored.

Test Plan:
- Write frame 55 01 00 10 03 11 22 33 -> three write requests: addr 0010/11, 0011/22, 0012/33. Then one Tx_start with AA; Busy low after DONE; no Err.
- Read frame 55 02 FF FE 03, controller returns 5A, 6B, 7C -> read addresses FFFE, FFFF, 0000 (wrap). Tx bytes 5A, 6B, 7C, each sent only after the prior Tx_done.
- Bad frames: 55 07 -> Err pulse, back to IDLE. 55 01 00 00 00 -> Err (LEN=0). 55 01 00 00 11 with MAX_LEN=16 -> Err. Stray byte 3C in IDLE -> no Err.
- Timeout: 55 01 00 then silence for TIMEOUT_CYC (set 100 in sim) -> Err at cycle 100. A following valid frame executes normally.
- Rx byte injected while waiting for Eep_ack -> Err pulse. Write completes with the original data.
- Rst_n low for 1 cycle while Eep_wr_req is high -> all outputs 0 next cycle. A late Eep_ack is ignored and the FSM stays in IDLE.
